// File: rtl/router_scheduler.sv
// Layer sequencer for the weight and input router controllers: launches both per pixel,
// gates FIFO pops under PE-array backpressure, relaunches weights per output-channel context.
module router_scheduler #(
   parameter int ADDR_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [CNT_WIDTH-1:0] i_num_pixels,
   output logic                 o_wc_en,
   output logic                 o_wc_reg_clear,
   output logic                 o_wc_pop_en,
   input  logic                 i_wc_ready,
   input  logic                 i_wc_context_done,
   input  logic                 i_wc_done,
   output logic                 o_ic_en,
   output logic                 o_ic_reg_clear,
   output logic                 o_ic_pop_en,
   input  logic                 i_ic_ready,
   input  logic                 i_array_ready,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [CNT_WIDTH-1:0] o_pixel_cnt,
   output logic [CNT_WIDTH-1:0] o_context_cnt
);

   if (ADDR_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
      $error("router_scheduler: widths must be positive");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LAUNCH, S_WAIT_READY,
      S_STREAM, S_RELAUNCH, S_PIXEL_END, S_FINISH
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [CNT_WIDTH-1:0] r_num_pixels;
   logic [CNT_WIDTH-1:0] r_pixel_cnt;
   logic [CNT_WIDTH-1:0] r_context_cnt;
   logic                 r_wc_rdy_s;
   logic                 r_ic_rdy_s;
   logic                 r_wc_en;
   logic                 r_ic_en;
   logic                 r_wc_clr;
   logic                 r_ic_clr;
   logic                 r_done;
   logic                 w_both_ready;
   logic                 w_last_pixel;

   // The live strobes are OR'd in so a ready arriving this cycle counts without waiting for its flag.
   assign w_both_ready = (r_wc_rdy_s | i_wc_ready) & (r_ic_rdy_s | i_ic_ready);
   assign w_last_pixel = (r_pixel_cnt == r_num_pixels - CNT_WIDTH'(1));

   // NOTE: next state is defaulted to the current state first so no path leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (i_start) w_next = (i_num_pixels == '0) ? S_FINISH : S_CLEAR;
         S_CLEAR:      w_next = S_LAUNCH;
         S_LAUNCH:     w_next = S_WAIT_READY;
         S_WAIT_READY: if (w_both_ready) w_next = S_STREAM;
         S_STREAM: begin
            if (i_wc_done)              w_next = S_PIXEL_END;
            else if (i_wc_context_done) w_next = S_RELAUNCH;
         end
         S_RELAUNCH:   w_next = S_LAUNCH;
         S_PIXEL_END:  w_next = w_last_pixel ? S_FINISH : S_CLEAR;
         S_FINISH:     w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
      if (i_abort) w_next = S_IDLE;
   end

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_num_pixels  <= '0;
         r_pixel_cnt   <= '0;
         r_context_cnt <= '0;
         r_wc_rdy_s    <= 1'b0;
         r_ic_rdy_s    <= 1'b0;
         r_wc_en       <= 1'b0;
         r_ic_en       <= 1'b0;
         r_wc_clr      <= 1'b0;
         r_ic_clr      <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_wc_clr <= 1'b0;
         r_ic_clr <= 1'b0;
         r_done   <= 1'b0;
         if (i_abort) begin
            if (r_state != S_IDLE) begin
               r_wc_clr <= 1'b1;
               r_ic_clr <= 1'b1;
            end
            r_wc_en    <= 1'b0;
            r_ic_en    <= 1'b0;
            r_wc_rdy_s <= 1'b0;
            r_ic_rdy_s <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_start) begin
                     r_num_pixels  <= i_num_pixels;
                     r_pixel_cnt   <= '0;
                     r_context_cnt <= '0;
                  end
               end
               S_CLEAR: begin
                  r_wc_clr   <= 1'b1;
                  r_ic_clr   <= 1'b1;
                  r_wc_en    <= 1'b0;
                  r_ic_en    <= 1'b0;
                  r_wc_rdy_s <= 1'b0;
                  r_ic_rdy_s <= 1'b0;
               end
               S_LAUNCH: begin
                  r_wc_en <= 1'b1;
                  r_ic_en <= 1'b1;
               end
               S_WAIT_READY: begin
                  if (i_wc_ready) r_wc_rdy_s <= 1'b1;
                  if (i_ic_ready) r_ic_rdy_s <= 1'b1;
               end
               S_STREAM: begin
                  // A simultaneous done owns the context increment in PIXEL_END.
                  if (!i_wc_done && i_wc_context_done) r_context_cnt <= r_context_cnt + CNT_WIDTH'(1);
               end
               S_RELAUNCH: begin
                  r_wc_en    <= 1'b0;
                  r_wc_rdy_s <= 1'b0;
               end
               S_PIXEL_END: begin
                  r_context_cnt <= r_context_cnt + CNT_WIDTH'(1);
                  if (!w_last_pixel) r_pixel_cnt <= r_pixel_cnt + CNT_WIDTH'(1);
               end
               S_FINISH: begin
                  r_done  <= 1'b1;
                  r_wc_en <= 1'b0;
                  r_ic_en <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign o_wc_en        = r_wc_en;
   assign o_ic_en        = r_ic_en;
   assign o_wc_reg_clear = r_wc_clr;
   assign o_ic_reg_clear = r_ic_clr;
   assign o_wc_pop_en    = (r_state == S_STREAM) & i_array_ready;
   assign o_ic_pop_en    = (r_state == S_STREAM) & i_array_ready;
   assign o_busy         = (r_state != S_IDLE);
   assign o_done         = r_done;
   assign o_pixel_cnt    = r_pixel_cnt;
   assign o_context_cnt  = r_context_cnt;

endmodule

// File: doc/router_scheduler.md
Name: router_scheduler

Overview:
- Layer-level sequencer above the router controllers: the weight controller and the input (activation) controller.
- Per output pixel, launches both controllers and waits until both report tile data ready.
- Gates FIFO pops to the PE array under array backpressure, re-launches the weight controller for each output-channel context, and advances to the next pixel when the weight controller signals done.
- Pulses a layer-done when every pixel has been processed.

Parameters:
- ADDR_WIDTH, 8, width of the size/config fields.
- CNT_WIDTH, 16, width of the pixel and context counters.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  one-cycle pulse; begin a layer (ignored unless IDLE).
- i_abort  in  1  return to IDLE from any state.
- i_num_pixels  in  CNT_WIDTH  output spatial positions in the layer (H*W); latched on i_start.
- o_wc_en  out  1  weight controller enable (level).
- o_wc_reg_clear  out  1  weight controller clear pulse.
- o_wc_pop_en  out  1  weight FIFO pop request.
- i_wc_ready  in  1  weight tile ready.
- i_wc_context_done  in  1  weight context finished, more channels remain.
- i_wc_done  in  1  all output channels finished for this pixel.
- o_ic_en  out  1  input controller enable (level).
- o_ic_reg_clear  out  1  input controller clear pulse.
- o_ic_pop_en  out  1  input FIFO pop request.
- i_ic_ready  in  1  input tile ready.
- i_array_ready  in  1  PE array can accept data this cycle.
- o_busy  out  1  high in any state except IDLE.
- o_done  out  1  one-cycle pulse at layer completion.
- o_pixel_cnt  out  CNT_WIDTH  current pixel index.
- o_context_cnt  out  CNT_WIDTH  contexts completed in the current layer.

Behaviour:
- Reset (i_rst high at a clock edge):
  - State goes to IDLE.
  - All outputs and counters are 0.
  - Sticky flags wc_rdy_s and ic_rdy_s are cleared.
- IDLE:
  - On i_start, latch i_num_pixels and zero both counters.
  - If the latched count is 0, go to FINISH; otherwise go to CLEAR.
- CLEAR (1 cycle):
  - o_wc_reg_clear = o_ic_reg_clear = 1.
  - o_wc_en = o_ic_en = 0.
  - Clear the sticky flags, then go to LAUNCH.
- LAUNCH (1 cycle):
  - Set o_wc_en = o_ic_en = 1; they stay high until the next CLEAR, RELAUNCH, FINISH or abort.
  - Go to WAIT_READY.
- WAIT_READY:
  - Set wc_rdy_s on i_wc_ready and ic_rdy_s on i_ic_ready; the flags hold because the two readies may arrive in different cycles.
  - When both flags are set (including the same-cycle arrival case), go to STREAM.
- STREAM:
  - o_wc_pop_en = o_ic_pop_en = i_array_ready, combinational from state. This gives zero-latency backpressure: no pop is issued in a cycle where i_array_ready = 0.
  - On i_wc_done, go to PIXEL_END.
  - Otherwise, on i_wc_context_done, increment o_context_cnt and go to RELAUNCH.
  - If both strobes arrive in the same cycle, done wins; the context is counted once, in PIXEL_END.
- RELAUNCH (1 cycle):
  - o_wc_en = 0, with no weight clear, so the controller keeps its channel position.
  - o_ic_en stays 1 and input data is reused.
  - Clear wc_rdy_s only, then go to LAUNCH; ic_rdy_s stays set so only weight readiness is re-awaited.
- PIXEL_END (1 cycle):
  - Increment o_context_cnt.
  - If o_pixel_cnt == num_pixels-1, go to FINISH.
  - Otherwise increment o_pixel_cnt and go to CLEAR.
- FINISH:
  - o_done = 1 for exactly one cycle; enables drop to 0.
  - Go to IDLE.
- Abort and start rules:
  - i_abort in any non-IDLE state drives both reg_clear pulses for 1 cycle, zeroes the enables and returns to IDLE.
  - o_done does not pulse on abort.
  - i_abort has priority over every other input.
  - i_start while busy is ignored.
- Counters:
  - Wrap modulo 2^CNT_WIDTH.
  - Only the pixel compare uses the latched num_pixels; i_num_pixels may change after start.
- Other rules:
  - Controller strobes are ignored outside their consuming state.
  - Pops never assert outside STREAM.

Test Plan:
- num_pixels=2; weight controller model raises context_done once, then done, for each pixel. Required: o_context_cnt=4 at the end; o_pixel_cnt sequence 0,1; exactly one o_done; 2 CLEAR pulses on each reg_clear.
- i_ic_ready 3 cycles before i_wc_ready. Required: STREAM entered the cycle after i_wc_ready; no pops before it. Repeat with both readies in the same cycle.
- In STREAM, toggle i_array_ready 1,0,0,1. Required: pops follow it exactly (1,0,0,1) on both FIFOs.
- i_wc_context_done and i_wc_done asserted in the same cycle. Required: single PIXEL_END; o_context_cnt increments by 1 only.
- i_start with i_num_pixels=0. Required: o_done pulses 2 cycles later; enables and pops stay 0.
- i_abort mid-STREAM, then a later i_rst mid-WAIT_READY. Required: abort gives one reg_clear pulse, IDLE, and no o_done; reset zeroes all outputs on the next edge.
